// File: rtl/tri_cosine_core.sv
// Triangle cosine engine: loads three sides serially, classifies the triangle and
// streams the three angle cosines (signed Q2.13) from a shared restoring divider.
module tri_cosine_core #(
    parameter int LEN_W   = 8,
    parameter int FRAC_W  = 13,
    parameter int OUT_W   = 16,
    parameter int DIV_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [LEN_W-1:0] in_length,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_cos,
    output logic [1:0]       out_tri
);
    localparam int SQ_W  = 2 * LEN_W;
    localparam int N_W   = SQ_W + 2;
    localparam int D_W   = SQ_W + 1;
    localparam int X_W   = N_W + FRAC_W;
    localparam int CNT_W = $clog2(DIV_CYC);
    localparam logic [DIV_CYC-1:0] ONE_Q = DIV_CYC'(1) << FRAC_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DIV, S_OUT} state_e;

    state_e              state_q;
    logic [LEN_W-1:0]    len_q [3];
    logic                ld_q;
    logic [N_W-1:0]      mag_q [3];
    logic                neg_q [3];
    logic [D_W-1:0]      den_q [3];
    logic [1:0]          tri_q;
    logic [1:0]          idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [D_W-1:0]      rem_q;
    logic [DIV_CYC-1:0]  sh_q, quo_q;
    logic [OUT_W-1:0]    cos_q [3];
    logic                out_valid_q;
    logic [OUT_W-1:0]    out_cos_q;
    logic [1:0]          out_tri_q;

    // Squares, cosine numerators/denominators and classification from the stored sides
    logic [SQ_W-1:0]       sq [3];
    logic [SQ_W-1:0]       pr [3];
    logic signed [N_W-1:0] num [3];
    logic [N_W-1:0]        mag_d [3];
    logic [N_W-1:0]        tot;
    logic [LEN_W:0]        psum;
    logic                  bad, obt, rt;
    logic [1:0]            tri_d;

    always_comb begin
        bad  = 1'b0;
        obt  = 1'b0;
        rt   = 1'b0;
        psum = '0;
        for (int k = 0; k < 3; k++) sq[k] = SQ_W'(len_q[k]) * SQ_W'(len_q[k]);
        tot = N_W'(sq[0]) + N_W'(sq[1]) + N_W'(sq[2]);
        for (int k = 0; k < 3; k++) begin
            num[k]   = $signed(tot - (N_W'(sq[k]) << 1));
            mag_d[k] = num[k][N_W-1] ? N_W'(-num[k]) : N_W'(num[k]);
            pr[k]    = SQ_W'(len_q[(k+1)%3]) * SQ_W'(len_q[(k+2)%3]);
            psum     = {1'b0, len_q[(k+1)%3]} + {1'b0, len_q[(k+2)%3]};
            if (len_q[k] == '0 || psum <= {1'b0, len_q[k]}) bad = 1'b1;
            if (num[k] < 0) obt = 1'b1;
            if (num[k] == 0) rt = 1'b1;
        end
        tri_d = bad ? 2'b11 : obt ? 2'b10 : rt ? 2'b01 : 2'b00;
    end

    // One restoring step; the first step of each division seeds from |N| << FRAC_W
    logic [X_W-1:0]     x0;
    logic [D_W-1:0]     r_in, rem_nxt;
    logic [DIV_CYC-1:0] sh_in, quo_in, quo_nxt, sat;
    logic [D_W:0]       trial;
    logic               ge;
    logic [OUT_W-1:0]   mag_o, cos_res;

    always_comb begin
        x0      = {mag_q[idx_q], {FRAC_W{1'b0}}};
        r_in    = (cnt_q == '0) ? D_W'(x0 >> DIV_CYC) : rem_q;
        sh_in   = (cnt_q == '0) ? x0[DIV_CYC-1:0] : sh_q;
        quo_in  = (cnt_q == '0) ? '0 : quo_q;
        trial   = {r_in, sh_in[DIV_CYC-1]};
        ge      = trial >= {1'b0, den_q[idx_q]};
        rem_nxt = ge ? D_W'(trial - {1'b0, den_q[idx_q]}) : trial[D_W-1:0];
        quo_nxt = {quo_in[DIV_CYC-2:0], ge};
        sat     = (quo_nxt > ONE_Q) ? ONE_Q : quo_nxt;
        mag_o   = OUT_W'(sat);
        cos_res = neg_q[idx_q] ? (~mag_o + 1'b1) : mag_o;
        if (tri_q == 2'b11) cos_res = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_q        <= 1'b0;
            tri_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            sh_q        <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            out_cos_q   <= '0;
            out_tri_q   <= '0;
            for (int k = 0; k < 3; k++) begin
                len_q[k] <= '0;
                mag_q[k] <= '0;
                neg_q[k] <= 1'b0;
                den_q[k] <= '0;
                cos_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    len_q[0] <= in_length;
                    ld_q     <= 1'b0;
                    state_q  <= S_LOAD;
                end
                S_LOAD: begin
                    if (!ld_q) begin
                        len_q[1] <= in_length;
                        ld_q     <= 1'b1;
                    end else begin
                        len_q[2] <= in_length;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    for (int k = 0; k < 3; k++) begin
                        mag_q[k] <= mag_d[k];
                        neg_q[k] <= num[k] < 0;
                        den_q[k] <= {pr[k], 1'b0};
                    end
                    tri_q   <= tri_d;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    sh_q  <= {sh_in[DIV_CYC-2:0], 1'b0};
                    quo_q <= quo_nxt;
                    if (cnt_q == CNT_W'(DIV_CYC - 1)) begin
                        cnt_q        <= '0;
                        cos_q[idx_q] <= cos_res;
                        if (idx_q == 2'd2) begin
                            out_valid_q <= 1'b1;
                            out_cos_q   <= cos_q[0];
                            out_tri_q   <= tri_q;
                            idx_q       <= 2'd1;
                            state_q     <= S_OUT;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (idx_q == 2'd3) begin
                        out_valid_q <= 1'b0;
                        out_cos_q   <= '0;
                        out_tri_q   <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        out_cos_q <= cos_q[idx_q];
                        idx_q     <= idx_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_cos   = out_cos_q;
    assign out_tri   = out_tri_q;
endmodule

// File: tb/tb_tri_cosine_core.sv
// Bench for tri_cosine_core: directed triangles, reset mid-division and a long
// back-to-back random run compared against an integer/real cosine model.
module tb_tri_cosine_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_length;
    logic        out_valid;
    logic [15:0] out_cos;
    logic [1:0]  out_tri;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tri_cosine_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_length(in_length),
        .out_valid(out_valid),
        .out_cos  (out_cos),
        .out_tri  (out_tri)
    );

    function automatic logic [1:0] ref_class(input int a, input int b, input int c);
        int l, s1, s2;
        if (a >= b && a >= c) begin l = a; s1 = b; s2 = c; end
        else if (b >= c)      begin l = b; s1 = a; s2 = c; end
        else                  begin l = c; s1 = a; s2 = b; end
        if (a == 0 || b == 0 || c == 0 || s1 + s2 <= l) return 2'b11;
        if (s1*s1 + s2*s2 == l*l) return 2'b01;
        if (s1*s1 + s2*s2 >  l*l) return 2'b00;
        return 2'b10;
    endfunction

    // cosine of the angle opposite x, truncated toward zero in Q2.13
    function automatic int ref_cos(input int x, input int y, input int z);
        int n, q;
        n = y*y + z*z - x*x;
        q = ((n < 0 ? -n : n) * 8192) / (2*y*z);
        if (q > 8192) q = 8192;
        return (n < 0) ? -q : q;
    endfunction

    // Caller must be at a negedge; returns at the negedge after out_valid falls.
    task automatic run_tri(input int a, input int b, input int c, input logic [1:0] etri,
                           input int e0, input int e1, input int e2, input string tag);
        int n, ov;
        int ec[3];
        int sd[3];
        logic [15:0] want;
        real cr, got;
        ec = '{e0, e1, e2};
        sd = '{a, b, c};
        ov = 0;
        in_valid = 1'b1; in_length = 8'(a);
        if (out_valid !== 1'b0) ov++;
        @(negedge clk); in_length = 8'(b);
        if (out_valid !== 1'b0) ov++;
        @(negedge clk); in_length = 8'(c);
        if (out_valid !== 1'b0) ov++;
        @(negedge clk); in_valid = 1'b0; in_length = 8'd0;
        checks++;
        if (ov != 0) begin
            errors++;
            $display("FAIL %s overlap: out_valid high %0d times during input, expected 0", tag, ov);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n != 49) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 49", tag, n);
        end
        for (int k = 0; k < 3; k++) begin
            want = 16'(ec[k]);
            checks++;
            if (out_valid !== 1'b1 || out_cos !== want || out_tri !== etri) begin
                errors++;
                $display("FAIL %s burst%0d: valid=%b cos=%0d tri=%b, expected valid=1 cos=%0d tri=%b",
                         tag, k, out_valid, $signed(out_cos), out_tri, ec[k], etri);
            end
            if (etri != 2'b11) begin
                cr  = $itor(sd[(k+1)%3]**2 + sd[(k+2)%3]**2 - sd[k]**2) /
                      $itor(2 * sd[(k+1)%3] * sd[(k+2)%3]);
                got = $itor($signed(out_cos)) / 8192.0;
                checks++;
                if (got - cr >= 1.0/8192.0 || cr - got >= 1.0/8192.0) begin
                    errors++;
                    $display("FAIL %s tol%0d: cos=%f, expected %f within 1/8192", tag, k, got, cr);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || out_cos !== 16'd0 || out_tri !== 2'b00) begin
            errors++;
            $display("FAIL %s end: valid=%b cos=%0d tri=%b, expected all 0",
                     tag, out_valid, $signed(out_cos), out_tri);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_length = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_cos !== 16'd0 || out_tri !== 2'b00) begin
            errors++;
            $display("FAIL reset: valid=%b cos=%0d tri=%b, expected all 0", out_valid, out_cos, out_tri);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_tri(3, 4, 5, 2'b01, 6553, 4915, 0, "right345");
        run_tri(7, 7, 7, 2'b00, 4096, 4096, 4096, "equi7");
        run_tri(255, 255, 255, 2'b00, 4096, 4096, 4096, "equi255");
        run_tri(2, 3, 4, 2'b10, 7168, 5632, -2048, "obtuse234");
        run_tri(1, 2, 3, 2'b11, 0, 0, 0, "degen123");
        run_tri(0, 5, 5, 2'b11, 0, 0, 0, "zero055");
        run_tri(5, 3, 4, 2'b01, 0, 6553, 4915, "right534");
    endtask

    task automatic test_reset_mid_div();
        int hi;
        in_valid = 1'b1; in_length = 8'd3;
        @(negedge clk); in_length = 8'd4;
        @(negedge clk); in_length = 8'd5;
        @(negedge clk); in_valid = 1'b0; in_length = 8'd0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cos !== 16'd0 || out_tri !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: valid=%b cos=%0d tri=%b, expected all 0", out_valid, out_cos, out_tri);
        end
        @(negedge clk); rst_n = 1'b1;
        hi = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL rst_noburst: out_valid high %0d cycles, expected 0", hi);
        end
        run_tri(3, 4, 5, 2'b01, 6553, 4915, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int a, b, c, lo, hi;
        logic [1:0] t;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(1, 255);
            b = $urandom_range(1, 255);
            lo = (a > b) ? a - b + 1 : b - a + 1;
            hi = (a + b - 1 > 255) ? 255 : a + b - 1;
            c = $urandom_range(lo, hi);
            case ($urandom_range(0, 9))
                0: c = $urandom_range(0, 255);
                1: a = 0;
                default: ;
            endcase
            t = ref_class(a, b, c);
            if (t == 2'b11)
                run_tri(a, b, c, t, 0, 0, 0, "rand");
            else
                run_tri(a, b, c, t, ref_cos(a, b, c), ref_cos(b, c, a), ref_cos(c, a, b), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
